// File: rtl/jtframe_bank_pkg.sv
// jtframe_bank_pkg: shared types and sizes for the SDRAM bank scheduler
package jtframe_bank_pkg;
  localparam int NBANK  = 4;
  localparam int TOUT_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  function automatic logic [1:0] oh2idx(input logic [NBANK-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/jtframe_rr_pick.sv
// jtframe_rr_pick: combinational 4-way round-robin picker searching from ptr+1
module jtframe_rr_pick
  import jtframe_bank_pkg::*;
(
  input  logic [NBANK-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [NBANK-1:0] gnt_o,
  output logic             vld_o
);
  assign vld_o = |req_i;
  always_comb begin
    gnt_o = '0;
    for (int i = 1; i <= NBANK; i++)
      if (req_i[ptr_i + 2'(i)] && gnt_o == '0) gnt_o[ptr_i + 2'(i)] = 1'b1;
  end
endmodule

// File: rtl/jtframe_bank_sched.sv
// jtframe_bank_sched: 4-bank/download SDRAM command scheduler; JTFRAME_BANK_TIMEOUT_EN adds a WAIT watchdog
module jtframe_bank_sched
  import jtframe_bank_pkg::*;
#(
  parameter int SDRAMW = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    downloading,
  input  logic [4*SDRAMW-1:0]     ba_addr,
  input  logic [NBANK-1:0]        ba_rd,
  input  logic [NBANK-1:0]        ba_wr,
  output logic [NBANK-1:0]        ba_ack,
  output logic [NBANK-1:0]        ba_rdy,
  input  logic [SDRAMW-1:0]       prog_addr,
  input  logic [1:0]              prog_ba,
  input  logic                    prog_rd,
  input  logic                    prog_we,
  output logic                    prog_ack,
  output logic                    prog_rdy,
  output logic                    cmd_req,
  output logic [1:0]              cmd_ba,
  output logic [SDRAMW-1:0]       cmd_addr,
  output logic                    cmd_wr,
  input  logic                    cmd_ack,
  input  logic                    cmd_rdy,
  output logic                    busy,
  output logic                    timeout
);
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, cmd_ba_q, cmd_ba_d, gidx;
  logic [SDRAMW-1:0] cmd_addr_q, cmd_addr_d;
  logic [NBANK-1:0] breq, gnt, sel_oh, ack_q, ack_d, rdy_q, rdy_d;
  logic prog_q, prog_d, cmd_req_q, cmd_req_d, cmd_wr_q, cmd_wr_d;
  logic pack_q, pack_d, prdy_q, prdy_d, vld, expire;
  assign breq   = downloading ? '0 : ba_rd | ba_wr;
  assign gidx   = oh2idx(gnt);
  assign sel_oh = NBANK'(1) << sel_q;
  jtframe_rr_pick u_pick (.req_i(breq), .ptr_i(ptr_q), .gnt_o(gnt), .vld_o(vld));
`ifdef JTFRAME_BANK_TIMEOUT_EN
  logic [TOUT_W-1:0] cnt_q;
  logic tout_q;
  assign expire  = state_q == WAIT && !cmd_rdy && cnt_q == TOUT_W'(2**TOUT_W - 2);
  assign timeout = tout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= state_q == WAIT ? cnt_q + 1'b1 : '0;
      tout_q <= tout_q | expire;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    prog_d     = prog_q;
    cmd_req_d  = cmd_req_q;
    cmd_ba_d   = cmd_ba_q;
    cmd_addr_d = cmd_addr_q;
    cmd_wr_d   = cmd_wr_q;
    ack_d      = '0;
    rdy_d      = '0;
    pack_d     = 1'b0;
    prdy_d     = 1'b0;
    case (state_q)
      IDLE: if (downloading ? prog_rd | prog_we : vld) begin
        state_d    = ISSUE;
        cmd_req_d  = 1'b1;
        prog_d     = downloading;
        sel_d      = gidx;
        cmd_ba_d   = downloading ? prog_ba : gidx;
        cmd_addr_d = downloading ? prog_addr : ba_addr[gidx*SDRAMW +: SDRAMW];
        cmd_wr_d   = downloading ? prog_we : ba_wr[gidx];
      end
      ISSUE: if (cmd_ack) begin
        cmd_req_d = 1'b0;
        ack_d     = prog_q ? '0 : sel_oh;
        pack_d    = prog_q;
        rdy_d     = cmd_rdy && !prog_q ? sel_oh : '0;
        prdy_d    = cmd_rdy & prog_q;
        ptr_d     = cmd_rdy && !prog_q ? sel_q : ptr_q;
        state_d   = cmd_rdy ? IDLE : WAIT;
      end
      WAIT: if (cmd_rdy || expire) begin
        rdy_d   = cmd_rdy && !prog_q ? sel_oh : '0;
        prdy_d  = cmd_rdy & prog_q;
        ptr_d   = prog_q ? ptr_q : sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      sel_q      <= '0;
      prog_q     <= 1'b0;
      cmd_req_q  <= 1'b0;
      cmd_ba_q   <= '0;
      cmd_addr_q <= '0;
      cmd_wr_q   <= 1'b0;
      ack_q      <= '0;
      rdy_q      <= '0;
      pack_q     <= 1'b0;
      prdy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      prog_q     <= prog_d;
      cmd_req_q  <= cmd_req_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wr_q   <= cmd_wr_d;
      ack_q      <= ack_d;
      rdy_q      <= rdy_d;
      pack_q     <= pack_d;
      prdy_q     <= prdy_d;
    end
  end
  assign cmd_req  = cmd_req_q;
  assign cmd_ba   = cmd_ba_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_wr   = cmd_wr_q;
  assign ba_ack   = ack_q;
  assign ba_rdy   = rdy_q;
  assign prog_ack = pack_q;
  assign prog_rdy = prdy_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_jtframe_bank_sched.sv
// tb_jtframe_bank_sched: directed scoreboard bench for jtframe_bank_sched (honours JTFRAME_BANK_TIMEOUT_EN)
module tb_jtframe_bank_sched;
  localparam int SDRAMW = 22;
  typedef struct {
    logic [1:0]        ba;
    logic [SDRAMW-1:0] addr;
    logic              wr;
    logic              prog;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, downloading = 1'b0;
  logic [4*SDRAMW-1:0] ba_addr;
  logic [3:0] ba_rd = '0, ba_wr = '0, ba_ack, ba_rdy;
  logic [SDRAMW-1:0] prog_addr = 22'h2ABCD, cmd_addr;
  logic [1:0] prog_ba = 2'd1, cmd_ba;
  logic prog_rd = 1'b0, prog_we = 1'b0, prog_ack, prog_rdy;
  logic cmd_req, cmd_wr, cmd_ack = 1'b0, cmd_rdy = 1'b0, busy, timeout;
  logic [SDRAMW-1:0] addr_tab [4] = '{22'h012345, 22'h0ABCDE, 22'h155AA5, 22'h3FFF01};
  exp_t sb[$];
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  jtframe_bank_sched #(.SDRAMW(SDRAMW)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ba_addr(ba_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_rd(prog_rd), .prog_we(prog_we),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy), .cmd_req(cmd_req), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_ack(cmd_ack), .cmd_rdy(cmd_rdy),
    .busy(busy), .timeout(timeout)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_bank(input int n, input bit wr);
    sb.push_back('{2'(n), addr_tab[n], wr, 1'b0});
  endtask
  task automatic pop(output exp_t e);
    if (sb.size() == 0) begin
      $display("FAIL sb_underflow: observed empty expected entry");
      $fatal(1, "scoreboard empty");
    end
    e = sb.pop_front();
  endtask
  task automatic wait_req();
    int n = 0;
    while (cmd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", cmd_req, 1'b1);
  endtask
  task automatic chk_cmd(input exp_t e);
    chk("cmd_ba", cmd_ba, e.ba);
    chk("cmd_addr", cmd_addr, e.addr);
    chk("cmd_wr", cmd_wr, e.wr);
  endtask
  task automatic serve(input int ad, input int rd, input bit same, input bit drop);
    exp_t e;
    logic [4:0] oh;
    wait_req();
    pop(e);
    oh = e.prog ? 5'b10000 : 5'(1) << e.ba;
    chk_cmd(e);
    repeat (ad) begin
      tick();
      chk("req_hold", cmd_req, 1'b1);
      chk("addr_hold", cmd_addr, e.addr);
      chk("ack_early", {prog_ack, ba_ack}, 5'b0);
    end
    cmd_ack = 1'b1;
    cmd_rdy = same;
    if (drop) begin
      if (e.prog) begin
        prog_rd = 1'b0;
        prog_we = 1'b0;
      end else begin
        ba_rd[e.ba] = 1'b0;
        ba_wr[e.ba] = 1'b0;
      end
    end
    tick();
    cmd_ack = 1'b0;
    cmd_rdy = 1'b0;
    chk("ack", {prog_ack, ba_ack}, oh);
    chk("req_drop", cmd_req, 1'b0);
    if (same) begin
      chk("rdy_same", {prog_rdy, ba_rdy}, oh);
      chk("idle_same", busy, 1'b0);
    end else begin
      chk("rdy_early", {prog_rdy, ba_rdy}, 5'b0);
      chk("busy_wait", busy, 1'b1);
      tick();
      chk("ack_pulse", {prog_ack, ba_ack}, 5'b0);
      repeat (rd - 1) tick();
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      chk("rdy", {prog_rdy, ba_rdy}, oh);
      chk("idle", busy, 1'b0);
    end
    tick();
    chk("rdy_pulse", {prog_rdy, ba_rdy}, 5'b0);
    chk("ack_once", {prog_ack, ba_ack}, 5'b0);
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {cmd_req, cmd_ba, cmd_addr, cmd_wr, ba_ack, ba_rdy, prog_ack, prog_rdy, busy, timeout}, 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    for (int n = 0; n < 4; n++) ba_addr[n*SDRAMW +: SDRAMW] = addr_tab[n];
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    // Round robin with all banks requesting
    ba_rd = 4'b1111;
    for (int n = 0; n < 5; n++) push_bank(n % 4, 1'b0);
    for (int n = 0; n < 4; n++) serve(2, 2, 1'b0, 1'b0);
    ba_rd = 4'b0001;
    serve(2, 2, 1'b0, 1'b1);
    chk("rr_idle", busy, 1'b0);
    // Download owns the SDRAM
    downloading = 1'b1;
    prog_we = 1'b1;
    ba_rd[2] = 1'b1;
    sb.push_back('{2'd1, 22'h2ABCD, 1'b1, 1'b1});
    serve(2, 2, 1'b0, 1'b1);
    repeat (3) begin
      tick();
      chk("dl_hold", cmd_req, 1'b0);
    end
    downloading = 1'b0;
    push_bank(2, 1'b0);
    serve(1, 1, 1'b0, 1'b1);
    // One-cycle request with delayed ack
    ba_rd[1] = 1'b1;
    push_bank(1, 1'b0);
    tick();
    ba_rd[1] = 1'b0;
    chk("latency", cmd_req, 1'b1);
    serve(5, 2, 1'b0, 1'b0);
    // Same-cycle ack and rdy, rd+wr treated as write
    ba_rd[3] = 1'b1;
    ba_wr[3] = 1'b1;
    push_bank(3, 1'b1);
    serve(2, 0, 1'b1, 1'b1);
    chk("same_noreq", cmd_req, 1'b0);
    // Reset during WAIT
    ba_rd = 4'b0101;
    push_bank(0, 1'b0);
    push_bank(2, 1'b0);
    serve(1, 1, 1'b0, 1'b1);
    wait_req();
    pop(e);
    chk_cmd(e);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("rst_ack", ba_ack, 4'b0100);
    tick();
    chk("rst_busy", busy, 1'b1);
    rst = 1'b1;
    cmd_rdy = 1'b1;
    tick();
    rst = 1'b0;
    cmd_rdy = 1'b0;
    chk_zero("rst_wait");
    ba_rd = 4'b0101;
    push_bank(0, 1'b0);
    push_bank(2, 1'b0);
    serve(1, 1, 1'b0, 1'b1);
    serve(1, 1, 1'b0, 1'b1);
    // Never-answered transfer
    ba_rd = 4'b1001;
    push_bank(3, 1'b0);
    wait_req();
    pop(e);
    chk_cmd(e);
    cmd_ack = 1'b1;
    ba_rd[3] = 1'b0;
    tick();
    cmd_ack = 1'b0;
    chk("to_ack", ba_ack, 4'b1000);
    repeat (254) tick();
    chk("to_pre", timeout, 1'b0);
    chk("to_busy_pre", busy, 1'b1);
    tick();
`ifdef JTFRAME_BANK_TIMEOUT_EN
    chk("timeout", timeout, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_nordy", ba_rdy, 4'b0);
`else
    chk("timeout", timeout, 1'b0);
    chk("to_busy", busy, 1'b1);
    cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    chk("late_rdy", ba_rdy, 4'b1000);
`endif
    push_bank(0, 1'b0);
    serve(1, 1, 1'b0, 1'b1);
`ifdef JTFRAME_BANK_TIMEOUT_EN
    chk("to_sticky", timeout, 1'b1);
`else
    chk("to_tied", timeout, 1'b0);
`endif
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
